// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter that shares one 4-bit ripple adder
// between NREQ requesters. The result is held in a single output register
// until the consumer accepts it.

// 4-bit ripple-carry adder built from 1-bit full adder cells
module full_adder_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_cout = w_c[4];
endmodule

module add_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_sum,
  output logic              rsp_cout,
  output logic [ID_W-1:0]   rsp_id
);
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [ID_W-1:0] r_ptr;
  logic [3:0]      r_sum;
  logic            r_cout;
  logic [ID_W-1:0] r_id;

  logic            w_grant_vld;
  logic [ID_W-1:0] w_grant_id;
  logic            w_can_accept;
  logic            w_xfer;
  logic [ID_W-1:0] w_ptr_next;
  logic [3:0]      w_op_a;
  logic [3:0]      w_op_b;
  logic [3:0]      w_sum;
  logic            w_cout;
  logic [3:0]      w_a_arr [NREQ];
  logic [3:0]      w_b_arr [NREQ];

  // Unpack the operand buses into per-requester nibbles
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = req_a[4*gi +: 4];
      assign w_b_arr[gi] = req_b[4*gi +: 4];
    end
  endgenerate

  // Round-robin scan: first valid requester at or after r_ptr, wrapping
  always_comb begin
    int idx;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_grant_vld && req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ID_W'(idx);
      end
    end
  end

  // The single shared adder, fed by the granted requester's operands
  assign w_op_a = w_a_arr[w_grant_id];
  assign w_op_b = w_b_arr[w_grant_id];

  full_adder_4 u_adder (
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_ptr_next = (w_grant_id == ID_W'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;

  // Output register state: hold, load on transfer, empty on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  // Next-state, accept and ready logic; ready is held low during reset
  always_comb begin
    w_state_next = r_state;
    w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
    w_xfer       = w_grant_vld & w_can_accept & rst_n;
    req_ready    = '0;
    if (w_xfer) begin
      req_ready    = NREQ'(1) << w_grant_id;
      w_state_next = ST_FULL;
    end else if ((r_state == ST_FULL) && rsp_ready) begin
      w_state_next = ST_EMPTY;
    end
  end

  // Result payload and round-robin pointer update on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_id   <= w_grant_id;
      r_ptr  <= w_ptr_next;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_id    = r_id;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed plus random stimulus with a queue scoreboard.
module tb_add_arbiter;
  localparam int N    = 4;
  localparam int ID_W = $clog2(N);

  typedef struct packed {
    logic            cout;
    logic [3:0]      sum;
    logic [ID_W-1:0] id;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_a;
  logic [4*N-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [3:0]      rsp_sum;
  logic            rsp_cout;
  logic [ID_W-1:0] rsp_id;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];
  int   m_ptr;
  bit   m_full;

  add_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One cycle of stimulus; reference model predicts grant and result
  task automatic step(input logic [N-1:0] v, input logic [4*N-1:0] a,
                      input logic [4*N-1:0] b, input logic rr,
                      output logic [N-1:0] granted);
    int g;
    int s;
    logic [N-1:0] exp_rdy;
    rsp_t e;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (g >= 0 && (!m_full || rr)) exp_rdy[g] = 1'b1;
    @(negedge clk);
    check("req_ready", int'(req_ready), int'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != '0) begin
      s      = int'(a[4*g +: 4]) + int'(b[4*g +: 4]);
      e.cout = (s >= 16);
      e.sum  = 4'(s % 16);
      e.id   = ID_W'(g);
      sb.push_back(e);
      m_ptr  = (g + 1) % N;
      m_full = 1'b1;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
    granted = exp_rdy;
    #1;
  endtask

  // Monitor: compare the held result against the scoreboard head
  always @(negedge clk) begin
    rsp_t got;
    if (rst_n) begin
      checks++;
      if (rsp_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL rsp_valid: got %b expected %b", rsp_valid, sb.size() != 0);
      end else if (rsp_valid) begin
        got = {rsp_cout, rsp_sum, rsp_id};
        checks++;
        if (got !== sb[0]) begin
          errors++;
          $display("FAIL rsp: got id=%0d sum=%0d cout=%0d expected id=%0d sum=%0d cout=%0d",
                   got.id, got.sum, got.cout, sb[0].id, sb[0].sum, sb[0].cout);
        end
        if (rsp_ready) begin
          $display("rsp id=%0d sum=%0d cout=%0d", got.id, got.sum, got.cout);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N-1:0]   gr;
    logic [N-1:0]   pv;
    logic [4*N-1:0] pa;
    logic [4*N-1:0] pb;
    rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_ptr = 0; m_full = 1'b0;
    #2;
    check("reset_req_ready", int'(req_ready), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_sum",   int'(rsp_sum), 0);
    check("reset_rsp_id",    int'(rsp_id), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    // single request, then overflow from requester 2
    step(4'b0001, 16'h0003, 16'h0004, 1'b1, gr);
    step(4'b0000, 16'h0000, 16'h0000, 1'b1, gr);
    step(4'b0100, 16'h0F00, 16'h0100, 1'b1, gr);
    step(4'b0100, 16'h0F00, 16'h0F00, 1'b1, gr);
    step(4'b0000, 16'h0000, 16'h0000, 1'b1, gr);
    step(4'b0000, 16'h0000, 16'h0000, 1'b1, gr);
    // load id=1, then asynchronous reset between edges
    step(4'b0010, 16'h0050, 16'h0020, 1'b1, gr);
    req_valid = '1; rsp_ready = 1'b0;
    check("pre_reset_valid", int'(rsp_valid), 1);
    check("pre_reset_id",    int'(rsp_id), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid", int'(rsp_valid), 0);
    check("mid_reset_rsp_sum",   int'(rsp_sum), 0);
    check("mid_reset_rsp_id",    int'(rsp_id), 0);
    check("mid_reset_req_ready", int'(req_ready), 0);
    sb.delete(); m_ptr = 0; m_full = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    // all four valid: ids 0,1,2,3 back to back, ptr wraps to 0
    for (int i = 0; i < 5; i++) step(4'b1111, 16'h9876, 16'hFEDC, 1'b1, gr);
    // backpressure for 5 cycles, then drain with same-edge reload
    for (int i = 0; i < 5; i++) step(4'b1111, 16'h9876, 16'hFEDC, 1'b0, gr);
    step(4'b1111, 16'h9876, 16'hFEDC, 1'b1, gr);
    // fairness between requesters 0 and 2
    for (int i = 0; i < 8; i++) step(4'b0101, 16'h0A05, 16'h0307, 1'b1, gr);
    step(4'b0000, 16'h0000, 16'h0000, 1'b1, gr);
    // randomized producers holding pairs until granted
    pv = '0; pa = '0; pb = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pa[4*i +: 4] = 4'($urandom_range(0, 15));
          pb[4*i +: 4] = 4'($urandom_range(0, 15));
        end else if (pv[i] && $urandom_range(0, 31) == 0) begin
          pv[i] = 1'b0;
        end
      end
      step(pv, pa, pb, 1'($urandom_range(0, 3) != 0), gr);
      pv = pv & ~gr;
    end
    step(4'b0000, 16'h0000, 16'h0000, 1'b1, gr);
    step(4'b0000, 16'h0000, 16'h0000, 1'b1, gr);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
